// File: rtl/sha256_msg_loader_if.sv
// Bundle of the loader's handshake and memory-bus signals.
// slave  : the loader itself.
// master : whatever surrounds it (message source, engine, RAM, digest sink).
interface sha256_msg_loader_if;
    // job control
    logic        go;
    logic [15:0] input_addr;
    logic [15:0] hash_addr;
    logic        busy;
    logic        error;

    // message word stream
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;

    // engine handshake
    logic        sha_start;
    logic        sha_done;

    // shared word-addressed memory
    logic        mem_grant;
    logic        memory_we;
    logic [15:0] memory_addr;
    logic [31:0] memory_write_data;
    logic [31:0] memory_read_data;

    // digest word stream
    logic        hash_valid;
    logic        hash_ready;
    logic [31:0] hash_data;
    logic        hash_last;

    modport slave (
        input  go, input_addr, hash_addr,
        output busy, error,
        input  in_valid, in_data,
        output in_ready,
        output sha_start,
        input  sha_done,
        output mem_grant, memory_we, memory_addr, memory_write_data,
        input  memory_read_data,
        output hash_valid, hash_data, hash_last,
        input  hash_ready
    );

    modport master (
        output go, input_addr, hash_addr,
        input  busy, error,
        output in_valid, in_data,
        input  in_ready,
        input  sha_start,
        output sha_done,
        input  mem_grant, memory_we, memory_addr, memory_write_data,
        output memory_read_data,
        input  hash_valid, hash_data, hash_last,
        output hash_ready
    );
endinterface

// File: rtl/sha256_msg_loader.sv
// SHA-256 message loader / digest reader.
// Streams NUM_OF_WORDS message words into the shared RAM, kicks the engine,
// waits (with timeout) for it to finish, then reads the 8 digest words back
// out of the RAM and presents them on an output stream.
module sha256_msg_loader #(
    parameter int NUM_OF_WORDS   = 40,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sha256_msg_loader_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        KICK,
        WAIT_BUSY,
        WAIT_DONE,
        READ,
        OUT
    } state_t;

    localparam logic [9:0]  LAST_WORD = 10'(NUM_OF_WORDS - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [15:0] in_base_q;
    logic [15:0] hash_base_q;
    logic [9:0]  cnt_q;
    logic [15:0] tmo_q;
    logic [3:0]  rd_k_q;
    logic [2:0]  idx_q;
    logic [31:0] buf_q [8];

    logic        in_ready_q;
    logic        sha_start_q;
    logic        mem_grant_q;
    logic        hash_valid_q;
    logic        hash_last_q;
    logic [31:0] hash_data_q;
    logic        busy_q;
    logic        error_q;

    // in_ready_q is only ever high in LOAD, so it doubles as the write qualifier
    logic        accept_d;
    logic        timeout_d;
    logic [2:0]  idx_next_d;

    assign accept_d   = in_ready_q & bus.in_valid;
    assign timeout_d  = (tmo_q == TMO_LAST);
    assign idx_next_d = idx_q + 3'd1;

    // Memory bus: message writes are combinational so a word lands the cycle it is accepted
    always_comb begin
        // NOTE: every output gets a default first so no path through the block leaves
        // a signal unassigned; otherwise synthesis infers a latch.
        bus.memory_we         = 1'b0;
        bus.memory_addr       = 16'h0000;
        bus.memory_write_data = 32'h0000_0000;
        case (state_q)
            LOAD: begin
                bus.memory_addr = in_base_q + 16'(cnt_q);
                if (accept_d) begin
                    bus.memory_we         = 1'b1;
                    bus.memory_write_data = bus.in_data;
                end
            end
            READ: begin
                // rd_k_q==8 is the final capture cycle; the extra read it issues is harmless
                bus.memory_addr = hash_base_q + 16'(rd_k_q);
            end
            default: ;
        endcase
    end

    // Control FSM with all handshake outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            in_base_q    <= 16'h0000;
            hash_base_q  <= 16'h0000;
            cnt_q        <= 10'd0;
            tmo_q        <= 16'h0000;
            rd_k_q       <= 4'd0;
            idx_q        <= 3'd0;
            in_ready_q   <= 1'b0;
            sha_start_q  <= 1'b0;
            mem_grant_q  <= 1'b1;
            hash_valid_q <= 1'b0;
            hash_last_q  <= 1'b0;
            hash_data_q  <= 32'h0000_0000;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every register samples
            // the pre-edge values regardless of statement order.
            sha_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.go) begin
                        in_base_q   <= bus.input_addr;
                        hash_base_q <= bus.hash_addr;
                        cnt_q       <= 10'd0;
                        error_q     <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= LOAD;
                    end
                end

                LOAD: begin
                    if (accept_d) begin
                        cnt_q <= cnt_q + 10'd1;
                        if (cnt_q == LAST_WORD) begin
                            in_ready_q  <= 1'b0;
                            sha_start_q <= 1'b1;
                            mem_grant_q <= 1'b0;
                            tmo_q       <= 16'h0000;
                            state_q     <= KICK;
                        end
                    end
                end

                KICK: begin
                    state_q <= WAIT_BUSY;
                end

                WAIT_BUSY: begin
                    if (timeout_d) begin
                        error_q     <= 1'b1;
                        mem_grant_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                        if (!bus.sha_done) begin
                            state_q <= WAIT_DONE;
                        end
                    end
                end

                WAIT_DONE: begin
                    if (timeout_d) begin
                        error_q     <= 1'b1;
                        mem_grant_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else if (bus.sha_done) begin
                        mem_grant_q <= 1'b1;
                        rd_k_q      <= 4'd0;
                        state_q     <= READ;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end

                READ: begin
                    rd_k_q <= rd_k_q + 4'd1;
                    if (rd_k_q == 4'd8) begin
                        // buf_q[0] was captured long ago; buf_q[7] lands on this same edge
                        hash_valid_q <= 1'b1;
                        hash_last_q  <= 1'b0;
                        hash_data_q  <= buf_q[0];
                        idx_q        <= 3'd0;
                        state_q      <= OUT;
                    end
                end

                OUT: begin
                    if (bus.hash_ready) begin
                        if (idx_q == 3'd7) begin
                            hash_valid_q <= 1'b0;
                            hash_last_q  <= 1'b0;
                            busy_q       <= 1'b0;
                            state_q      <= IDLE;
                        end else begin
                            idx_q       <= idx_next_d;
                            hash_data_q <= buf_q[idx_next_d];
                            hash_last_q <= (idx_next_d == 3'd7);
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Digest capture: RAM data for address k arrives one cycle later, in READ step k+1
    always_ff @(posedge clk) begin
        // NOTE: the digest buffer is plain storage with no reset; it is always fully
        // written in READ before OUT can present any of it.
        if (state_q == READ && rd_k_q != 4'd0) begin
            buf_q[3'(rd_k_q - 4'd1)] <= bus.memory_read_data;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.sha_start  = sha_start_q;
    assign bus.mem_grant  = mem_grant_q;
    assign bus.hash_valid = hash_valid_q;
    assign bus.hash_last  = hash_last_q;
    assign bus.hash_data  = hash_data_q;
    assign bus.busy       = busy_q;
    assign bus.error      = error_q;

endmodule

// File: tb/tb_sha256_msg_loader.sv
// Self-checking bench for sha256_msg_loader: a registered RAM shared through a
// mem_grant mux, a behavioural engine that writes a digest while it owns the RAM,
// randomized message/digest traffic, and a second small instance for the timeout path.
module tb_sha256_msg_loader;

    localparam int NW = 40;

    logic clk;
    logic rst_n;

    sha256_msg_loader_if ifc ();
    sha256_msg_loader_if ifc_t ();

    sha256_msg_loader #(.NUM_OF_WORDS(NW), .TIMEOUT_CYCLES(4096)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    sha256_msg_loader #(.NUM_OF_WORDS(2), .TIMEOUT_CYCLES(16)) u_dut_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int          cyc = 0;
    int          start_cnt = 0;
    int          done_rise_cyc = 0;
    int          eng_hold = 10;
    int          grant_viol = 0;
    logic [15:0] job_ha;
    logic [31:0] dig   [8];
    logic [31:0] words [NW];

    // engine side of the memory mux
    logic        eng_we;
    logic [15:0] eng_addr;
    logic [31:0] eng_wdata;

    logic [31:0] mem [0:65535];
    logic        mux_we;
    logic [15:0] mux_addr;
    logic [31:0] mux_wdata;

    assign mux_we    = ifc.mem_grant ? ifc.memory_we         : eng_we;
    assign mux_addr  = ifc.mem_grant ? ifc.memory_addr       : eng_addr;
    assign mux_wdata = ifc.mem_grant ? ifc.memory_write_data : eng_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Registered shared RAM
    always @(posedge clk) begin
        if (mux_we) mem[mux_addr] <= mux_wdata;
        ifc.memory_read_data <= mem[mux_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // The loader must never write while the engine owns the bus
    always @(negedge clk) begin
        if (ifc.memory_we && !ifc.mem_grant) grant_viol <= grant_viol + 1;
    end

    // Behavioural engine: on start, leave idle, write digest to hash area, stay busy, finish
    initial begin
        ifc.sha_done = 1'b1;
        eng_we       = 1'b0;
        eng_addr     = 16'h0000;
        eng_wdata    = 32'h0;
        forever begin
            @(negedge clk);
            if (ifc.sha_start) begin
                start_cnt++;
                @(posedge clk); #1;
                ifc.sha_done = 1'b0;
                check("eng_grant", ifc.mem_grant, 1'b0);
                for (int k = 0; k < 8; k++) begin
                    eng_we    = 1'b1;
                    eng_addr  = job_ha + 16'(k);
                    eng_wdata = dig[k];
                    @(posedge clk); #1;
                end
                eng_we = 1'b0;
                repeat (eng_hold) @(posedge clk);
                #1;
                ifc.sha_done  = 1'b1;
                done_rise_cyc = cyc;
            end
        end
    end

    // go pulse with latency checks; ends at posedge+1 with the loader in LOAD
    task automatic start_job(input logic [15:0] ia, input logic [15:0] ha);
        @(posedge clk); #1;
        ifc.go         = 1'b1;
        ifc.input_addr = ia;
        ifc.hash_addr  = ha;
        @(negedge clk);
        check("pre_go_ready", ifc.in_ready, 1'b0);
        @(posedge clk); #1;
        ifc.go         = 1'b0;
        ifc.input_addr = 16'hDEAD;
        ifc.hash_addr  = 16'hBEEF;
        @(negedge clk);
        check("go_ready", ifc.in_ready, 1'b1);
        check("go_busy", ifc.busy, 1'b1);
        check("go_error", ifc.error, 1'b0);
        @(posedge clk); #1;
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random valid
    task automatic feed(input int n, input int mode);
        int   i = 0;
        int   guard = 0;
        logic acc;
        while (i < n && guard < 5000) begin
            case (mode)
                1:       ifc.in_valid = (guard % 2 == 0);
                2:       ifc.in_valid = ($urandom_range(0, 1) == 1);
                default: ifc.in_valid = 1'b1;
            endcase
            ifc.in_data = words[i];
            @(negedge clk);
            acc = ifc.in_valid && ifc.in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        ifc.in_valid = 1'b0;
        check("feed_count", 32'(i), 32'(n));
    endtask

    // Drain the digest stream; hold ready low 3 cycles on word stall_idx
    task automatic collect(input int stall_idx, input int mode);
        int k = 0;
        int n = 0;
        int stall_n = 0;
        bit first = 1'b1;
        while (k < 8 && n < 3000) begin
            if (ifc.hash_valid && k == stall_idx && stall_n < 3) begin
                ifc.hash_ready = 1'b0;
                stall_n++;
            end else begin
                ifc.hash_ready = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            @(negedge clk);
            if (ifc.hash_valid) begin
                if (first) begin
                    check("lat_done_valid", 32'(cyc - done_rise_cyc), 32'd10);
                    first = 1'b0;
                end
                check("hash_data", ifc.hash_data, dig[k]);
                check("hash_last", ifc.hash_last, (k == 7));
                if (ifc.hash_ready) k++;
            end
            @(posedge clk); #1;
            n++;
        end
        check("out_words", 32'(k), 32'd8);
        ifc.hash_ready = 1'b0;
        @(negedge clk);
        check("end_busy", ifc.busy, 1'b0);
        check("end_valid", ifc.hash_valid, 1'b0);
        check("end_grant", ifc.mem_grant, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic run_job(input logic [15:0] ia, input logic [15:0] ha, input int mode,
                           input bit seq, input int stall_idx, input int hold, input bit poke_go);
        int s0;
        for (int i = 0; i < NW; i++) words[i] = seq ? 32'(i) : $urandom;
        job_ha   = ha;
        eng_hold = hold;
        s0       = start_cnt;
        start_job(ia, ha);
        feed(NW, mode);
        @(negedge clk);
        check("kick_start", ifc.sha_start, 1'b1);
        check("kick_grant", ifc.mem_grant, 1'b0);
        check("kick_ready", ifc.in_ready, 1'b0);
        @(posedge clk); #1;
        if (poke_go) begin
            // go outside IDLE must be ignored, including its addresses
            repeat (20) @(posedge clk);
            #1;
            ifc.go         = 1'b1;
            ifc.input_addr = 16'h7777;
            ifc.hash_addr  = 16'h5555;
            @(posedge clk); #1;
            ifc.go = 1'b0;
            @(negedge clk);
            check("poke_ready", ifc.in_ready, 1'b0);
            check("poke_busy", ifc.busy, 1'b1);
            @(posedge clk); #1;
        end
        collect(stall_idx, mode);
        check("start_pulses", 32'(start_cnt - s0), 32'd1);
        for (int i = 0; i < NW; i++) begin
            check("mem_word", mem[16'(ia + 16'(i))], words[i]);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        ifc.go         = 1'b0;
        ifc.input_addr = 16'h0;
        ifc.hash_addr  = 16'h0;
        ifc.in_valid   = 1'b0;
        ifc.in_data    = 32'h0;
        ifc.hash_ready = 1'b0;
        ifc_t.go         = 1'b0;
        ifc_t.input_addr = 16'h0400;
        ifc_t.hash_addr  = 16'h0500;
        ifc_t.in_valid   = 1'b0;
        ifc_t.in_data    = 32'hCAFE_F00D;
        ifc_t.hash_ready = 1'b1;
        ifc_t.sha_done   = 1'b1;
        ifc_t.memory_read_data = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_ready", ifc.in_ready, 1'b0);
        check("rst_start", ifc.sha_start, 1'b0);
        check("rst_grant", ifc.mem_grant, 1'b1);
        check("rst_we", ifc.memory_we, 1'b0);
        check("rst_addr", ifc.memory_addr, 16'h0);
        check("rst_wdata", ifc.memory_write_data, 32'h0);
        check("rst_hvalid", ifc.hash_valid, 1'b0);
        check("rst_hlast", ifc.hash_last, 1'b0);
        check("rst_hdata", ifc.hash_data, 32'h0);
        check("rst_busy", ifc.busy, 1'b0);
        check("rst_error", ifc.error, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // sequential message at 0, SHA-256 IV as digest, long engine run, ignored go
        dig[0] = 32'h6a09e667; dig[1] = 32'hbb67ae85; dig[2] = 32'h3c6ef372; dig[3] = 32'ha54ff53a;
        dig[4] = 32'h510e527f; dig[5] = 32'h9b05688c; dig[6] = 32'h1f83d9ab; dig[7] = 32'h5be0cd19;
        run_job(16'h0000, 16'h0100, 0, 1'b1, 8, 700, 1'b1);

        // toggling valid, output stall on word 4
        for (int k = 0; k < 8; k++) dig[k] = $urandom;
        run_job(16'h2000 + 16'($urandom_range(0, 255)), 16'h0180, 1, 1'b0, 4,
                $urandom_range(5, 40), 1'b0);

        // message wraps past 16'hFFFF
        for (int k = 0; k < 8; k++) dig[k] = $urandom;
        run_job(16'hFFF0, 16'h0140, 2, 1'b0, 8, $urandom_range(5, 40), 1'b0);
        check("wrap_lo", mem[16'h0000], words[16]);
        check("wrap_hi", mem[16'h0017], words[39]);

        // reset in the middle of LOAD after 20 words
        for (int i = 0; i < NW; i++) words[i] = $urandom;
        start_job(16'h0200, 16'h0300);
        feed(20, 0);
        ifc.in_valid = 1'b1;
        ifc.in_data  = words[20];
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", ifc.in_ready, 1'b0);
        check("mid_rst_we", ifc.memory_we, 1'b0);
        check("mid_rst_addr", ifc.memory_addr, 16'h0);
        check("mid_rst_wdata", ifc.memory_write_data, 32'h0);
        check("mid_rst_grant", ifc.mem_grant, 1'b1);
        check("mid_rst_busy", ifc.busy, 1'b0);
        check("mid_rst_start", ifc.sha_start, 1'b0);
        check("mid_rst_hvalid", ifc.hash_valid, 1'b0);
        check("mid_rst_hdata", ifc.hash_data, 32'h0);
        #2;
        rst_n        = 1'b1;
        ifc.in_valid = 1'b0;
        for (int k = 0; k < 8; k++) dig[k] = $urandom;
        run_job(16'h3000 + 16'($urandom_range(0, 255)), 16'h01C0, 2, 1'b0, 4,
                $urandom_range(5, 40), 1'b0);

        // timeout: engine never leaves idle, TIMEOUT_CYCLES=16
        begin
            int  n;
            int  w;
            bit  seen;
            bit  hv;
            @(posedge clk); #1;
            ifc_t.go = 1'b1;
            @(posedge clk); #1;
            ifc_t.go       = 1'b0;
            ifc_t.in_valid = 1'b1;
            seen = 1'b0;
            n    = 0;
            while (!seen && n < 50) begin
                @(negedge clk);
                if (ifc_t.sha_start) seen = 1'b1;
                n++;
            end
            ifc_t.in_valid = 1'b0;
            check("tmo_kick", seen, 1'b1);
            w  = 0;
            hv = 1'b0;
            n  = 0;
            while (n < 100) begin
                @(negedge clk);
                if (ifc_t.hash_valid) hv = 1'b1;
                if (!ifc_t.busy) break;
                w++;
                n++;
            end
            check("tmo_wait_cycles", 32'(w), 32'd16);
            check("tmo_error", ifc_t.error, 1'b1);
            check("tmo_no_hash", hv, 1'b0);
            check("tmo_grant", ifc_t.mem_grant, 1'b1);
            repeat (3) @(negedge clk);
            check("tmo_sticky", ifc_t.error, 1'b1);
            @(posedge clk); #1;
            ifc_t.go = 1'b1;
            @(posedge clk); #1;
            ifc_t.go = 1'b0;
            @(negedge clk);
            check("tmo_err_clear", ifc_t.error, 1'b0);
            check("tmo_rego_busy", ifc_t.busy, 1'b1);
        end

        check("grant_violations", 32'(grant_viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
